// File: rtl/buffered_async_operator_pkg.sv
// buffered_async_operator_pkg: op codes and pointer-width helper shared by the operator slice
package buffered_async_operator_pkg;
  typedef enum logic [3:0] {OP_REG, OP_IN, OP_OUT, OP_ADDI, OP_SUBI, OP_MULI, OP_ADD, OP_SUB, OP_MUL} op_e;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/operand_fifo.sv
// operand_fifo: synchronous FIFO with a combinational head read
module operand_fifo
  import buffered_async_operator_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] head,
  output logic full,
  output logic empty,
  output logic [clog2(depth):0] count
);
  localparam int aw = clog2(depth);
  logic [width-1:0] mem [depth];
  logic [aw-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  // a pop on the same edge frees the slot a push into a full queue needs
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = count == (aw+1)'(depth);
  assign empty = count == '0;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + aw'(do_push);
      rd_ptr <= rd_ptr + aw'(do_pop);
      count <= count + (aw+1)'(do_push) - (aw+1)'(do_pop);
    end
endmodule

// File: rtl/operator.sv
// operator: combinational dataflow operator over up to three operand lanes, lane 0 in the low slice
module operator
  import buffered_async_operator_pkg::*;
#(
  parameter int data_width = 32,
  parameter string op = "reg",
  parameter int immediate = 0,
  parameter int input_size = 1
) (
  input  logic [data_width*input_size-1:0] din,
  output logic [data_width-1:0] dout
);
  localparam op_e op_c = op == "add" ? OP_ADD : op == "sub" ? OP_SUB : op == "mul" ? OP_MUL :
    op == "addi" ? OP_ADDI : op == "subi" ? OP_SUBI : op == "muli" ? OP_MULI :
    op == "in" ? OP_IN : op == "out" ? OP_OUT : OP_REG;
  localparam logic [data_width-1:0] imm = data_width'(immediate);
  logic [data_width-1:0] x [3];
  // absent lanes take the identity value so add/sub/mul need no per-size variants
  for (genvar g = 0; g < 3; g++) begin : g_lane
    if (g < input_size) begin : g_used
      assign x[g] = din[g*data_width +: data_width];
    end else begin : g_unused
      assign x[g] = op_c == OP_MUL ? data_width'(1) : '0;
    end
  end
  always_comb
    dout = op_c == OP_ADDI ? x[0] + imm :
      op_c == OP_SUBI ? x[0] - imm :
      op_c == OP_MULI ? x[0] * imm :
      op_c == OP_ADD ? x[0] + x[1] + x[2] :
      op_c == OP_SUB ? x[0] - x[1] - x[2] :
      op_c == OP_MUL ? x[0] * x[1] * x[2] : x[0];
endmodule

// File: rtl/buffered_async_operator.sv
// buffered_async_operator: handshake operator with per-lane operand queues, a result queue and independent fan-out
module buffered_async_operator
  import buffered_async_operator_pkg::*;
#(
  parameter int data_width = 32,
  parameter string op = "reg",
  parameter int immediate = 0,
  parameter int input_size = 1,
  parameter int output_size = 1,
  parameter int depth = 4
) (
  input  logic clk,
  input  logic rst,
  output logic [input_size-1:0] req_l,
  input  logic [input_size-1:0] ack_l,
  input  logic [data_width*input_size-1:0] din,
  input  logic [output_size-1:0] req_r,
  output logic [output_size-1:0] ack_r,
  output logic [data_width-1:0] dout,
  output logic overflow
);
  localparam int cw = clog2(depth) + 1;
  logic [input_size-1:0] lane_full, lane_empty, lane_push;
  logic [data_width*input_size-1:0] heads;
  logic [cw-1:0] lane_count [input_size];
  logic [cw-1:0] res_count;
  logic [data_width-1:0] result, res_head;
  logic [output_size-1:0] served, grant;
  logic res_full, res_empty, res_pop, fire;
  assign lane_push = ack_l & ~lane_full;
  assign res_pop = &served;
  assign fire = ~|lane_empty & (~res_full | res_pop);
  // no grants on the pop edge, so every consumer sees each head exactly once
  assign grant = req_r & ~served & ~ack_r & {output_size{~res_empty & ~res_pop}};
  assign dout = res_count == '0 ? '0 : res_head;
  for (genvar g = 0; g < input_size; g++) begin : g_lane
    operand_fifo #(.width(data_width), .depth(depth)) u_fifo (
      .clk(clk), .rst(rst), .push(lane_push[g]), .pop(fire),
      .din(din[g*data_width +: data_width]), .head(heads[g*data_width +: data_width]),
      .full(lane_full[g]), .empty(lane_empty[g]), .count(lane_count[g])
    );
  end
  operator #(.data_width(data_width), .op(op), .immediate(immediate), .input_size(input_size)) u_op (
    .din(heads), .dout(result)
  );
  operand_fifo #(.width(data_width), .depth(depth)) u_res (
    .clk(clk), .rst(rst), .push(fire), .pop(res_pop), .din(result), .head(res_head),
    .full(res_full), .empty(res_empty), .count(res_count)
  );
  always_ff @(posedge clk)
    if (rst) begin
      req_l <= '0;
      ack_r <= '0;
      served <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < input_size; i++)
        req_l[i] <= (lane_count[i] + cw'(lane_push[i]) - cw'(fire) != cw'(depth)) & ~ack_l[i];
      ack_r <= grant;
      served <= res_pop ? '0 : served | grant;
      overflow <= overflow | |(ack_l & lane_full);
    end
endmodule

// File: tb/tb_buffered_async_operator.sv
// tb_buffered_async_operator: directed checks on an 8-bit add (2 lanes, 3 consumers) and an 8-bit addi instance
module tb_buffered_async_operator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int acks [3];
  int pushes [2];
  int n;
  logic [1:0] a_req_l;
  logic [1:0] a_ack_l = '0;
  logic [15:0] a_din = '0;
  logic [2:0] a_req_r = '0;
  logic [2:0] a_ack_r;
  logic [7:0] a_dout;
  logic a_ovf;
  logic b_req_l, b_ack_r, b_ovf;
  logic b_ack_l = 1'b0;
  logic b_req_r = 1'b0;
  logic [7:0] b_din = '0;
  logic [7:0] b_dout;

  buffered_async_operator #(.data_width(8), .op("add"), .input_size(2), .output_size(3), .depth(4)) u_add (
    .clk(clk), .rst(rst), .req_l(a_req_l), .ack_l(a_ack_l), .din(a_din),
    .req_r(a_req_r), .ack_r(a_ack_r), .dout(a_dout), .overflow(a_ovf)
  );
  buffered_async_operator #(.data_width(8), .op("addi"), .immediate(2), .input_size(1), .output_size(1), .depth(4)) u_addi (
    .clk(clk), .rst(rst), .req_l(b_req_l), .ack_l(b_ack_l), .din(b_din),
    .req_r(b_req_r), .ack_r(b_ack_r), .dout(b_dout), .overflow(b_ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int k = 1);
    repeat (k) @(negedge clk);
  endtask

  // all consumers request; consumer 0 sees results first..first+inc*(n-1), one every 2 cycles
  task automatic drain_a(input string tag, input int cnt, input logic [7:0] first, input logic [7:0] inc);
    int got = 0;
    int last = 0;
    a_req_r = '1;
    for (int c = 1; c <= 4 * cnt + 10 && got < cnt; c++) begin
      step();
      if (a_ack_r[0]) begin
        chk(tag, 32'(a_dout), 32'(8'(first + inc * got)));
        if (got > 0) chk({tag, "_gap"}, c - last, 2);
        last = c;
        got++;
      end
    end
    chk({tag, "_n"}, got, cnt);
    a_req_r = '0;
  endtask

  initial begin
    step(2);
    chk("rst_req_l", 32'(a_req_l), 0);
    chk("rst_ack_r", 32'(a_ack_r), 0);
    chk("rst_dout", 32'(a_dout), 0);
    chk("rst_ovf", 32'(a_ovf), 0);
    rst = 1'b0;
    step();
    chk("req_l_up", 32'(a_req_l), 2'b11);
    // single result: 5 + 7, ack_r three cycles after the second operand
    a_req_r = '1;
    a_ack_l = 2'b01;
    a_din = 16'h0005;
    step();
    chk("req_drop", 32'(a_req_l), 2'b10);
    a_ack_l = 2'b10;
    a_din = 16'h0700;
    step();
    a_ack_l = '0;
    step();
    chk("lat_early", 32'(a_ack_r), 0);
    step();
    chk("lat_ack", 32'(a_ack_r), 3'b111);
    chk("lat_dout", 32'(a_dout), 12);
    step();
    chk("lat_pulse", 32'(a_ack_r), 0);
    chk("lat_pop", 32'(a_dout), 0);
    a_req_r = '0;
    // addi wrap-around: 255 + 2 = 1, then 7 + 2 = 9
    b_req_r = 1'b1;
    b_ack_l = 1'b1;
    b_din = 8'd255;
    step();
    b_ack_l = 1'b0;
    step(2);
    chk("wrap_ack", 32'(b_ack_r), 1);
    chk("wrap_dout", 32'(b_dout), 1);
    b_ack_l = 1'b1;
    b_din = 8'd7;
    step();
    b_ack_l = 1'b0;
    step(2);
    chk("addi_ack", 32'(b_ack_r), 1);
    chk("addi_dout", 32'(b_dout), 9);
    // fan-out: consumers start requesting at offsets 0, 4, 10
    a_ack_l = 2'b11;
    a_din = {8'd50, 8'd100};
    step();
    a_ack_l = '0;
    step(3);
    acks = '{0, 0, 0};
    for (int i = 0; i < 20; i++) begin
      for (int j = 0; j < 3; j++)
        if (a_ack_r[j]) begin
          acks[j]++;
          chk($sformatf("fan_dout%0d", j), 32'(a_dout), 150);
        end
      if (i == 10) chk("fan_hold", 32'(a_dout), 150);
      if (i == 11) chk("fan_last", 32'(a_ack_r), 3'b100);
      a_req_r = {i >= 10, i >= 4, 1'b1};
      step();
    end
    for (int j = 0; j < 3; j++) chk($sformatf("fan_cnt%0d", j), acks[j], 1);
    chk("fan_popped", 32'(a_dout), 0);
    // backpressure: upstream acks whenever asked, nobody consumes
    a_req_r = '0;
    pushes = '{0, 0};
    for (int i = 0; i < 30; i++) begin
      a_ack_l = a_req_l;
      a_din = {8'(20 + pushes[1]), 8'(1 + pushes[0])};
      for (int j = 0; j < 2; j++) if (a_req_l[j]) pushes[j]++;
      step();
    end
    a_ack_l = '0;
    chk("bp_lane0", pushes[0], 8);
    chk("bp_lane1", pushes[1], 8);
    chk("bp_req_l", 32'(a_req_l), 0);
    chk("bp_ovf", 32'(a_ovf), 0);
    drain_a("bp", 8, 8'd21, 8'd2);
    // overflow: fifth ack into lane 0 is dropped and the flag sticks
    for (int i = 0; i < 5; i++) begin
      if (i == 4) chk("ovf_pre", 32'(a_ovf), 0);
      a_ack_l = 2'b01;
      a_din = {8'd0, 8'(i < 4 ? i + 1 : 99)};
      step();
    end
    a_ack_l = '0;
    chk("ovf_set", 32'(a_ovf), 1);
    for (int i = 0; i < 4; i++) begin
      a_ack_l = 2'b10;
      a_din = {8'd10, 8'd0};
      step();
    end
    a_ack_l = '0;
    drain_a("ovf", 4, 8'd11, 8'd1);
    chk("ovf_sticky", 32'(a_ovf), 1);
    // mid-operation reset with results, operands and a partly served head in flight
    a_req_r = 3'b001;
    for (int i = 0; i < 4; i++) begin
      a_ack_l = i < 2 ? 2'b11 : 2'b01;
      a_din = {8'(40 + i), 8'(i)};
      step();
    end
    a_ack_l = '0;
    step();
    rst = 1'b1;
    step();
    chk("mrst_ack_r", 32'(a_ack_r), 0);
    chk("mrst_dout", 32'(a_dout), 0);
    chk("mrst_ovf", 32'(a_ovf), 0);
    chk("mrst_req_l", 32'(a_req_l), 0);
    rst = 1'b0;
    a_req_r = '1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (a_ack_r != '0) n++;
    end
    chk("mrst_stale", n, 0);
    a_ack_l = 2'b11;
    a_din = {8'd4, 8'd3};
    step();
    a_ack_l = '0;
    drain_a("post_rst", 1, 8'd7, 8'd0);
    chk("b_req_l", 32'(b_req_l), 1);
    chk("b_ovf", 32'(b_ovf), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule
